// File: rtl/fetch_stage.sv
// Instruction fetch stage: drives a synchronous-read instruction memory, presents
// fetched instructions to decode, and handles stalls, redirects and misaligned faults.
module fetch_stage #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter logic [31:0] NOP      = 32'h0000_0013
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        stall,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic [31:0] imem_addr,
    output logic        imem_read_en,
    input  logic [31:0] imem_data,
    output logic [31:0] if_pc,
    output logic [31:0] if_instr,
    output logic        if_valid,
    output logic        fetch_fault,
    output logic [31:0] fetch_count
);

    typedef enum logic [1:0] {
        StIdle,
        StRun,
        StFault
    } state_e;

    state_e      state_q, state_d;
    logic [31:0] pc_f_q, pc_f_d;
    logic [31:0] req_pc_q, req_pc_d;
    logic [31:0] fetch_count_q, fetch_count_d;
    logic        fetch_fault_q, fetch_fault_d;
    logic        redirect_aligned;

    assign redirect_aligned = (redirect_pc[1:0] == 2'b00);

    // Next-state: redirect has top priority, then per-state sequencing.
    always_comb begin
        state_d       = state_q;
        pc_f_d        = pc_f_q;
        req_pc_d      = req_pc_q;
        fetch_count_d = fetch_count_q;
        fetch_fault_d = fetch_fault_q;

        if (redirect_valid) begin
            // The instruction presented this cycle is wrong-path and is not counted.
            req_pc_d = redirect_pc;
            if (redirect_aligned) begin
                pc_f_d        = redirect_pc + 32'd4;
                state_d       = StRun;
                fetch_fault_d = 1'b0;
            end else begin
                state_d       = StFault;
                fetch_fault_d = 1'b1;
            end
        end else begin
            case (state_q)
                StIdle: begin
                    req_pc_d = pc_f_q;
                    pc_f_d   = pc_f_q + 32'd4;
                    state_d  = StRun;
                end
                StRun: begin
                    if (!stall) begin
                        req_pc_d      = pc_f_q;
                        pc_f_d        = pc_f_q + 32'd4;
                        fetch_count_d = fetch_count_q + 32'd1;
                    end
                end
                StFault: begin
                    state_d = StFault;
                end
                default: begin
                    state_d = StIdle;
                end
            endcase
        end
    end

    // State registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q       <= StIdle;
            pc_f_q        <= RESET_PC;
            req_pc_q      <= RESET_PC;
            fetch_count_q <= 32'd0;
            fetch_fault_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            pc_f_q        <= pc_f_d;
            req_pc_q      <= req_pc_d;
            fetch_count_q <= fetch_count_d;
            fetch_fault_q <= fetch_fault_d;
        end
    end

    // Memory request and decode-facing outputs.
    always_comb begin
        if (redirect_valid) begin
            imem_addr = redirect_pc;
        end else if (stall) begin
            imem_addr = req_pc_q;  // re-read the held instruction
        end else begin
            imem_addr = pc_f_q;
        end

        // In FAULT the only read issued is the one fetching an aligned redirect target,
        // so that target can be presented on the following cycle.
        imem_read_en = !reset &&
                       ((state_q != StFault) || (redirect_valid && redirect_aligned));

        if_valid    = !reset && (state_q == StRun);
        if_pc       = reset ? RESET_PC : req_pc_q;
        if_instr    = if_valid ? imem_data : NOP;
        fetch_fault = fetch_fault_q;
        fetch_count = fetch_count_q;
    end

endmodule

// File: tb/tb_fetch_stage.sv
// Directed self-checking bench for fetch_stage with a synchronous-read memory model.
module tb_fetch_stage;

    localparam logic [31:0] NOP = 32'h0000_0013;

    logic        clk = 1'b0;
    logic        reset;
    logic        stall;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic [31:0] imem_addr;
    logic        imem_read_en;
    logic [31:0] imem_data = 32'd0;
    logic [31:0] if_pc;
    logic [31:0] if_instr;
    logic        if_valid;
    logic        fetch_fault;
    logic [31:0] fetch_count;

    logic [31:0] mem [64];

    int checks = 0;
    int errors = 0;

    fetch_stage dut (
        .clk            (clk),
        .reset          (reset),
        .stall          (stall),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .imem_addr      (imem_addr),
        .imem_read_en   (imem_read_en),
        .imem_data      (imem_data),
        .if_pc          (if_pc),
        .if_instr       (if_instr),
        .if_valid       (if_valid),
        .fetch_fault    (fetch_fault),
        .fetch_count    (fetch_count)
    );

    always #5 clk = ~clk;

    // Synchronous-read memory; addresses beyond the array return NOP.
    always @(posedge clk) begin
        if (imem_read_en) begin
            imem_data <= (imem_addr < 32'd256) ? mem[imem_addr[7:2]] : NOP;
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic settle();
        #1;
    endtask

    task automatic expect_present(input string tag, input logic [31:0] pc,
                                  input logic [31:0] instr);
        check({tag, ".valid"}, {31'd0, if_valid}, 32'd1);
        check({tag, ".pc"}, if_pc, pc);
        check({tag, ".instr"}, if_instr, instr);
    endtask

    initial begin
        for (int i = 0; i < 64; i++) mem[i] = 32'hA000_0000 + i;
        reset = 1'b1; stall = 1'b0; redirect_valid = 1'b0; redirect_pc = 32'd0;

        // Reset held
        tick(); tick(); settle();
        check("rst.valid", {31'd0, if_valid}, 32'd0);
        check("rst.instr", if_instr, NOP);
        check("rst.pc", if_pc, 32'd0);
        check("rst.rden", {31'd0, imem_read_en}, 32'd0);
        check("rst.count", fetch_count, 32'd0);
        check("rst.fault", {31'd0, fetch_fault}, 32'd0);

        // Cycle 1 after release: IDLE
        reset = 1'b0; settle();
        check("c1.valid", {31'd0, if_valid}, 32'd0);
        check("c1.addr", imem_addr, 32'd0);
        check("c1.rden", {31'd0, imem_read_en}, 32'd1);

        tick(); settle(); expect_present("c2", 32'h0, 32'hA000_0000);
        tick(); settle(); expect_present("c3", 32'h4, 32'hA000_0001);
        tick();
        // Stall three cycles while (8,C) is presented
        stall = 1'b1; settle();
        expect_present("stall0", 32'h8, 32'hA000_0002);
        check("stall0.addr", imem_addr, 32'h8);
        check("stall0.count", fetch_count, 32'd2);
        for (int i = 1; i < 3; i++) begin
            tick(); settle();
            expect_present("stallN", 32'h8, 32'hA000_0002);
            check("stallN.addr", imem_addr, 32'h8);
            check("stallN.count", fetch_count, 32'd2);
        end
        tick(); stall = 1'b0; settle();
        expect_present("stall_end", 32'h8, 32'hA000_0002);
        check("stall_end.count", fetch_count, 32'd2);
        tick(); settle();
        expect_present("c5", 32'hC, 32'hA000_0003);
        check("c5.count", fetch_count, 32'd3);

        // Stall and redirect together: redirect wins, D not counted
        stall = 1'b1; redirect_valid = 1'b1; redirect_pc = 32'h10; settle();
        check("sr.addr", imem_addr, 32'h10);
        tick(); stall = 1'b0; redirect_valid = 1'b0; settle();
        expect_present("sr", 32'h10, 32'hA000_0004);
        check("sr.count", fetch_count, 32'd3);
        tick(); settle(); expect_present("sr1", 32'h14, 32'hA000_0005);
        tick(); settle(); expect_present("sr2", 32'h18, 32'hA000_0006);
        check("sr2.count", fetch_count, 32'd5);

        // Reset asserted mid-stall after 5 delivered
        stall = 1'b1; tick();
        reset = 1'b1; settle();
        check("mrst.valid", {31'd0, if_valid}, 32'd0);
        check("mrst.instr", if_instr, NOP);
        check("mrst.pc", if_pc, 32'd0);
        check("mrst.rden", {31'd0, imem_read_en}, 32'd0);
        tick(); settle();
        check("mrst.count", fetch_count, 32'd0);
        reset = 1'b0; stall = 1'b0; settle();
        check("r1.valid", {31'd0, if_valid}, 32'd0);
        check("r1.addr", imem_addr, 32'd0);
        tick(); settle(); expect_present("r2", 32'h0, 32'hA000_0000);
        check("r2.count", fetch_count, 32'd0);
        tick();

        // Redirect to 0x20 while (4,B) presented
        redirect_valid = 1'b1; redirect_pc = 32'h20; settle();
        expect_present("rd0", 32'h4, 32'hA000_0001);
        check("rd0.count", fetch_count, 32'd1);
        tick(); redirect_valid = 1'b0; settle();
        expect_present("rd1", 32'h20, 32'hA000_0008);
        check("rd1.count", fetch_count, 32'd1);
        tick(); settle();
        expect_present("rd2", 32'h24, 32'hA000_0009);
        check("rd2.count", fetch_count, 32'd2);

        // Misaligned redirect faults
        redirect_valid = 1'b1; redirect_pc = 32'h22;
        tick(); redirect_valid = 1'b0; settle();
        check("flt.fault", {31'd0, fetch_fault}, 32'd1);
        check("flt.valid", {31'd0, if_valid}, 32'd0);
        check("flt.instr", if_instr, NOP);
        check("flt.rden", {31'd0, imem_read_en}, 32'd0);
        tick(); settle();
        check("flt2.fault", {31'd0, fetch_fault}, 32'd1);
        check("flt2.rden", {31'd0, imem_read_en}, 32'd0);
        check("flt2.count", fetch_count, 32'd2);

        // Aligned redirect clears the fault
        redirect_valid = 1'b1; redirect_pc = 32'h40; settle();
        check("fx.addr", imem_addr, 32'h40);
        check("fx.rden", {31'd0, imem_read_en}, 32'd1);
        tick(); redirect_valid = 1'b0; settle();
        expect_present("fx1", 32'h40, 32'hA000_0010);
        check("fx1.fault", {31'd0, fetch_fault}, 32'd0);
        tick(); settle();
        expect_present("fx2", 32'h44, 32'hA000_0011);
        check("fx2.count", fetch_count, 32'd3);

        // PC wrap at top of address space; out-of-range read presented as valid NOP
        redirect_valid = 1'b1; redirect_pc = 32'hFFFF_FFFC;
        tick(); redirect_valid = 1'b0; settle();
        expect_present("wr1", 32'hFFFF_FFFC, NOP);
        check("wr1.fault", {31'd0, fetch_fault}, 32'd0);
        check("wr1.count", fetch_count, 32'd3);
        tick(); settle();
        expect_present("wr2", 32'h0, 32'hA000_0000);
        check("wr2.count", fetch_count, 32'd4);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
